// File: rtl/seq_div.sv
// Radix-2 restoring sequential divider: one quotient bit per clock, start/busy/done handshake.
// Define SEQ_DIV_SIGNED_EN for two's-complement operands with truncating (C-style) results.
module seq_div #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [width-1:0] X,
  input  logic [width-1:0] Y,
  output logic [width-1:0] Q,
  output logic [width-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);
  localparam int CW = $clog2(width + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nxt;

  logic [width-1:0] rem, shft, dvs, mag_x, mag_y;
  logic [CW-1:0]    cnt;
  logic [width:0]   rem_sh, diff;
  logic [width-1:0] rem_nxt, q_nxt, q_fin, r_fin;
  logic             accept, last, ge;

  assign accept = start && (state != BUSY);
  assign last   = (state == BUSY) && (cnt == CW'(1));
  assign busy   = (state == BUSY);

  // Compare and subtract share one (width+1)-bit subtractor; its sign bit is the borrow.
  assign rem_sh  = {rem, shft[width-1]};
  assign diff    = rem_sh - {1'b0, dvs};
  assign ge      = ~diff[width];
  assign rem_nxt = ge ? diff[width-1:0] : rem_sh[width-1:0];
  assign q_nxt   = {shft[width-2:0], ge};

`ifdef SEQ_DIV_SIGNED_EN
  logic neg_q, neg_r;
  assign mag_x = X[width-1] ? -X : X;
  assign mag_y = Y[width-1] ? -Y : Y;
  assign q_fin = neg_q ? -q_nxt : q_nxt;
  assign r_fin = neg_r ? -rem_nxt : rem_nxt;
`else
  assign mag_x = X;
  assign mag_y = Y;
  assign q_fin = q_nxt;
  assign r_fin = rem_nxt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = (Y == '0) ? DONE : BUSY;
      BUSY:       if (last)  state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem      <= '0;
      shft     <= '0;
      dvs      <= '0;
      cnt      <= '0;
      Q        <= '0;
      R        <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (accept) begin
        div_zero <= (Y == '0);
        if (Y == '0) begin
          // Divide by zero resolves on the accept edge; no iterations run.
          Q    <= '1;
          R    <= X;
          done <= 1'b1;
        end else begin
          rem  <= '0;
          shft <= mag_x;
          dvs  <= mag_y;
          cnt  <= CW'(width);
`ifdef SEQ_DIV_SIGNED_EN
          neg_q <= X[width-1] ^ Y[width-1];
          neg_r <= X[width-1];
`endif
        end
      end else if (state == BUSY) begin
        rem  <= rem_nxt;
        shft <= q_nxt;
        cnt  <= cnt - CW'(1);
        if (last) begin
          Q    <= q_fin;
          R    <= r_fin;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_seq_div.sv
// Scoreboard bench for seq_div: arithmetic reference model plus cycle-level handshake model.
module tb_seq_div;
  localparam int W = 32;

  logic         clk = 1'b0, rst_n = 1'b1, start = 1'b0;
  logic [W-1:0] X = '0, Y = '0;
  logic [W-1:0] Q, R;
  logic         busy, done, div_zero;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } res_t;

  res_t sb[$];
  int   ecnt = 0, m_free_at = 0, m_done_at = -1, m_busy_lo = 0, m_busy_hi = 0;
  logic m_dz = 1'b0;
  int   errors = 0, checks = 0;

  seq_div #(.width(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .X(X), .Y(Y),
    .Q(Q), .R(R), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  function automatic res_t ref_div(logic [W-1:0] x, logic [W-1:0] y);
`ifdef SEQ_DIV_SIGNED_EN
    longint sx, sy;
`endif
    res_t r;
    r.dz = (y == '0);
    if (y == '0) begin
      r.q = '1;
      r.r = x;
    end else begin
`ifdef SEQ_DIV_SIGNED_EN
      sx  = longint'(signed'(x));
      sy  = longint'(signed'(y));
      r.q = W'(sx / sy);
      r.r = W'(sx % sy);
`else
      r.q = x / y;
      r.r = x % y;
`endif
    end
    return r;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h edge=%0d", nm, act, exp, ecnt - 1);
    end
  endtask

  // Handshake model: which edge accepts, when done fires, when busy is high.
  always @(posedge clk) begin
    ecnt <= ecnt + 1;
    if (!rst_n) begin
      m_free_at <= 0; m_done_at <= -1; m_busy_lo <= 0; m_busy_hi <= 0; m_dz <= 1'b0;
      sb.delete();
    end else if (start && ecnt >= m_free_at) begin
      sb.push_back(ref_div(X, Y));
      m_dz <= (Y == '0);
      if (Y == '0) begin
        m_done_at <= ecnt; m_busy_lo <= 0; m_busy_hi <= 0; m_free_at <= ecnt + 1;
      end else begin
        m_done_at <= ecnt + W; m_busy_lo <= ecnt; m_busy_hi <= ecnt + W; m_free_at <= ecnt + W + 1;
      end
    end
  end

  // Monitor: pops the scoreboard on done, otherwise demands Q/R hold the last result.
  initial begin
    res_t         e;
    logic [W-1:0] hq = '0, hr = '0;
    int           le;
    forever begin
      @(negedge clk);
      le = ecnt - 1;
      if (!rst_n) begin
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dz", div_zero, 0);
        chk("rst_q", Q, 0);
        chk("rst_r", R, 0);
        hq = '0; hr = '0;
      end else begin
        chk("busy", busy, (le >= m_busy_lo && le < m_busy_hi) ? 1 : 0);
        chk("done", done, (le == m_done_at) ? 1 : 0);
        chk("div_zero", div_zero, m_dz);
        if (done) begin
          if (sb.size() == 0) begin
            chk("unexpected_result", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("q", Q, e.q);
            chk("r", R, e.r);
            hq = e.q; hr = e.r;
          end
        end else begin
          chk("q_hold", Q, hq);
          chk("r_hold", R, hr);
        end
      end
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(logic [W-1:0] x, logic [W-1:0] y);
    start = 1'b1; X = x; Y = y;
    step(1);
    start = 1'b0; X = $urandom; Y = $urandom;
    step(W + 1);
  endtask

  initial begin
    logic [W-1:0] y;
    #1 rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(2);

    // Reset mid-operation discards the division
    start = 1'b1; X = 100; Y = 7;
    step(1);
    start = 1'b0;
    step(9);
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(W + 10);

    issue(100, 7);
    step(20);
    issue(32'hFFFF_FFFF, 1);
    issue(5, 9);
    issue(32'h8000_0000, 32'h8000_0000);
    issue(1234, 0);
    issue(50, 3);
    issue(32'hFFFF_FFF9, 2);
    issue(7, 32'hFFFF_FFFE);
    issue(32'h8000_0000, 32'hFFFF_FFFF);

    // Start held high, operands changing every cycle
    start = 1'b1;
    Y = $urandom_range(1, 1000);
    repeat (3 * (W + 1) + 3) begin
      X = $urandom;
      if ($urandom_range(0, 3) == 0) Y = $urandom;
      step(1);
    end
    start = 1'b0;
    step(W + 2);

    repeat (20) begin
      case ($urandom_range(0, 3))
        0:       y = '0;
        1:       y = W'($urandom_range(1, 15));
        default: y = $urandom;
      endcase
      issue($urandom, y);
      step($urandom_range(0, 3));
    end

    step(5);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seq_div.md
Name: seq_div

Overview:
- Multi-cycle sequential integer divider; the inverse operation of the combinational MUL datapath block.
- Computes Q = X / Y and R = X % Y using a radix-2 restoring algorithm, one quotient bit per clock.
- Sits beside MUL in the ALU/execute datapath.
- Controlled by a start/busy/done handshake so the control unit can stall until the result is valid.

Parameters:
- width, 32, operand and result bit width (legal range 2..64).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a division; sampled on rising clk
- X  input  width  dividend; sampled only on the accepting edge
- Y  input  width  divisor; sampled only on the accepting edge
- Q  output  width  quotient, registered
- R  output  width  remainder, registered
- busy  output  1  high while iterations are in progress
- done  output  1  single-cycle pulse when Q/R become valid
- div_zero  output  1  set with done when Y was 0; held until the next accepted start

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; Q=0, R=0, busy=0, done=0, div_zero=0; internal counter and working registers cleared. Applies immediately, including mid-operation; any in-flight division is discarded.
- States: IDLE, BUSY, DONE.
- Acceptance: start=1 on an edge while in IDLE or DONE. Call this edge E0. X and Y are latched at E0; later changes to X/Y have no effect.
- start while BUSY is ignored. No queueing and no restart.
- Normal path (Y!=0):
  - E0: load partial remainder = 0, shift register = X, count = width. Go to BUSY; busy=1.
  - Each BUSY edge: rem = {rem, msb(shift)}; shift <<= 1.
  - If rem >= Y: rem -= Y and the new quotient lsb = 1; otherwise lsb = 0.
  - Decrement count each iteration.
- Completion: on edge E_width (the width-th iteration), Q and R are written, busy drops, state goes to DONE, and done=1 for exactly one cycle.
  - Latency: width cycles from E0 to done.
  - Partial remainder is width+1 bits wide to avoid overflow on the compare.
- Divide by zero (Y==0 at E0):
  - No iterations. At E0, Q = all ones, R = X, div_zero=1, state DONE.
  - done=1 in the cycle after E0; busy is never asserted.
- DONE state: Q/R/div_zero hold their values. done falls to 0 after one cycle.
  - Stays in DONE with no new start; accepts a new start exactly like IDLE.
- Back-to-back: start held high continuously yields one result every width+1 cycles. At the edge after done, start is accepted again from DONE.
- Simultaneous start and completion: start on the completion edge is ignored because the state is BUSY at that edge.
- Q/R change only on a completion edge or on a divide-by-zero accept edge. They never show intermediate values.

Optional Feature:
- Macro: SEQ_DIV_SIGNED_EN.
- Defined: X/Y are two's complement with truncating (C-style) semantics.
  - Magnitudes are divided. Quotient is negated if sign(X) xor sign(Y). Remainder takes the sign of X.
  - Sign correction is applied on the completion edge, so latency is unchanged.
  - Most-negative / -1: Q = most-negative value (wrap), R = 0, div_zero = 0.
  - Divide by zero: Q = all ones (-1), R = X.
- Not defined: unsigned only, no sign logic is synthesized, behaviour as above.

Test Plan:
- Reset mid-op: start X=100, Y=7, assert rst_n=0 at cycle 10 -> busy, done, Q, R all 0 immediately. After release, no done pulse ever appears.
- Basic (width=32): X=100, Y=7, start one cycle -> busy for 32 cycles, then done pulses once with Q=14, R=2; Q/R held 20 cycles later.
- Boundaries: X=0xFFFFFFFF, Y=1 -> Q=0xFFFFFFFF, R=0. Then X=5, Y=9 -> Q=0, R=5. Then X=0x80000000, Y=0x80000000 -> Q=1, R=0.
- Divide by zero: X=1234, Y=0 -> busy never high, done in the cycle after the accept edge, Q=0xFFFFFFFF, R=1234, div_zero=1. The next valid start clears div_zero.
- Handshake: start held high with X changing every cycle -> the X sampled at each accept edge is used. Starts during BUSY are ignored, and a result arrives every 33 cycles.
- Signed (SEQ_DIV_SIGNED_EN): -7/2 -> Q=-3, R=-1; 7/-2 -> Q=-3, R=1; 0x80000000/-1 -> Q=0x80000000, R=0.
